// File: rtl/vec_xfer_ctrl_if.sv
// Handshake bundle for vec_xfer_ctrl: command channel, inbound element
// stream (host -> controller) and outbound element stream (controller -> host).
// The master side is the host/HAL link; the slave side is the controller.
interface vec_xfer_ctrl_if #(
  parameter int unsigned BITS  = 8,
  parameter int unsigned NREGS = 4
);

  localparam int unsigned RW = (NREGS > 1) ? $clog2(NREGS) : 1;

  // Command channel
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_store;
  logic [RW-1:0] cmd_reg;

  // Inbound element stream
  logic [BITS-1:0] s_data;
  logic            s_valid;
  logic            s_ready;

  // Outbound element stream
  logic [BITS-1:0] m_data;
  logic            m_valid;
  logic            m_ready;

  modport master (
    output cmd_valid, cmd_store, cmd_reg,
    output s_data, s_valid,
    output m_ready,
    input  cmd_ready, s_ready,
    input  m_data, m_valid
  );

  modport slave (
    input  cmd_valid, cmd_store, cmd_reg,
    input  s_data, s_valid,
    input  m_ready,
    output cmd_ready, s_ready,
    output m_data, m_valid
  );

endinterface

// File: rtl/vec_xfer_ctrl.sv
// vec_xfer_ctrl: moves whole vectors between a byte-element stream and a bank
// of NREGS vector registers.
//   load  : gather N elements into the staging buffer, then pulse the
//           selected register's set strobe for one cycle.
//   store : snapshot the selected register and stream it out element by element.
// Optional feature: define VEC_XFER_ABORT_EN to add an 'abort' input that
// cancels a load or store in flight (never a commit).
module vec_xfer_ctrl #(
  parameter int unsigned BITS  = 8,
  parameter int unsigned N     = 64,
  parameter int unsigned NREGS = 4,
  localparam int unsigned RW   = (NREGS > 1) ? $clog2(NREGS) : 1,
  localparam int unsigned IW   = (N > 1) ? $clog2(N) : 1
) (
  input  logic                clk,
  input  logic                rst,
`ifdef VEC_XFER_ABORT_EN
  input  logic                abort,
`endif
  vec_xfer_ctrl_if.slave      bus,
  output logic [BITS-1:0]     stage_vec [N-1:0],
  output logic [NREGS-1:0]    reg_set,
  output logic                reg_en,
  output logic [RW-1:0]       rd_sel,
  input  logic [BITS-1:0]     rd_vec [N-1:0],
  output logic                busy,
  output logic                done
);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StCommit,
    StCapture,
    StStore
  } state_e;

  state_e        state_q;
  logic [IW-1:0] idx_q;
  logic [RW-1:0] tgt_q;
  logic          done_q;

  logic idx_last;
  logic abort_hit;
  logic store_last;

  // Decode a register index to its set strobe; out-of-range indices give zero
  // so a bad target is dropped rather than aliasing onto another register.
  function automatic logic [NREGS-1:0] onehot(input logic [RW-1:0] r);
    logic [NREGS-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < NREGS; i++) begin
      v[i] = (32'(r) == i);
    end
    return v;
  endfunction

  assign idx_last = (idx_q == IW'(N - 1));

`ifdef VEC_XFER_ABORT_EN
  // Abort only applies to the data phases; IDLE has nothing to cancel and a
  // commit must always complete.
  assign abort_hit = abort &&
                     ((state_q == StLoad) || (state_q == StCapture) || (state_q == StStore));
`else
  assign abort_hit = 1'b0;
`endif

  // Final outbound beat: done must coincide with the handshake itself, so it
  // cannot come from a register.
  assign store_last = (state_q == StStore) && bus.m_ready && idx_last && !abort_hit;

  // Outputs decoded directly from the state register
  always_comb begin
    bus.cmd_ready = (state_q == StIdle);
    bus.s_ready   = (state_q == StLoad);
    bus.m_valid   = (state_q == StStore);
    bus.m_data    = stage_vec[idx_q];
    busy          = (state_q != StIdle);
    reg_en        = |reg_set;
    done          = done_q | store_last;
  end

  // Sequencer: state, element index, staging buffer and registered strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      tgt_q   <= '0;
      rd_sel  <= '0;
      reg_set <= '0;
      done_q  <= 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
        stage_vec[i] <= '0;
      end
    end else begin
      // Strobes are single-cycle unless re-armed below
      reg_set <= '0;
      done_q  <= 1'b0;
      if (abort_hit) begin
        state_q <= StIdle;
        idx_q   <= '0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (bus.cmd_valid) begin
              tgt_q   <= bus.cmd_reg;
              rd_sel  <= bus.cmd_reg;
              idx_q   <= '0;
              state_q <= bus.cmd_store ? StCapture : StLoad;
            end
          end
          StLoad: begin
            if (bus.s_valid) begin
              stage_vec[idx_q] <= bus.s_data;
              if (idx_last) begin
                idx_q   <= '0;
                state_q <= StCommit;
                reg_set <= onehot(tgt_q);
                done_q  <= 1'b1;
              end else begin
                idx_q <= idx_q + 1'b1;
              end
            end
          end
          StCommit: begin
            state_q <= StIdle;
          end
          StCapture: begin
            // rd_sel has been stable for a full cycle, so rd_vec is valid here
            stage_vec <= rd_vec;
            idx_q     <= '0;
            state_q   <= StStore;
          end
          StStore: begin
            if (bus.m_ready) begin
              if (idx_last) begin
                idx_q   <= '0;
                state_q <= StIdle;
              end else begin
                idx_q <= idx_q + 1'b1;
              end
            end
          end
          default: begin
            state_q <= StIdle;
            idx_q   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/vec_xfer_ctrl.md
Name: vec_xfer_ctrl

Overview:
Sequencer that moves whole vectors between a byte-element stream (host HAL link) and a bank of NREGS vector registers.
- Load: collects N elements from the input stream into a staging buffer, then commits them to the selected register in one cycle.
- Store: snapshots the selected register's output and emits it element-by-element on the output stream.
- Sits between the HAL transport and the vector register bank. It is the only writer of the bank's set/en lines.

Parameters:
BITS, 8, element width in bits
N, 64, elements per vector
NREGS, 4, number of vector registers in the bank; RW = max(1, $clog2(NREGS)), IW = max(1, $clog2(N))

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
cmd_store  in  1  0 = load (stream->reg), 1 = store (reg->stream)
cmd_reg  in  RW  target register index
s_data  in  BITS  incoming element
s_valid  in  1  incoming element valid
s_ready  out  1  controller accepting elements
m_data  out  BITS  outgoing element
m_valid  out  1  outgoing element valid
m_ready  in  1  downstream accepting
stage_vec  out  BITS x N (unpacked [N-1:0])  staging buffer, drives the bank's shared in bus
reg_set  out  NREGS  one-hot set strobe, one bit per register
reg_en  out  1  enable strobe to the bank, equal to |reg_set
rd_sel  out  RW  read-mux select for the bank output
rd_vec  in  BITS x N (unpacked [N-1:0])  muxed bank output for rd_sel
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle pulse at the end of each command

Behaviour:
Reset values:
- State IDLE; idx = 0; stage_vec all 0.
- reg_set = 0, reg_en = 0, m_valid = 0, m_data = 0, done = 0, busy = 0, rd_sel = 0.
- cmd_ready = 1 after reset (it is combinational: high only in IDLE). s_ready = 0.
- Reset mid-operation discards the partial vector. No reg_set pulse is issued for the aborted command.

States:
- IDLE: cmd_ready = 1. On handshake, latch cmd_reg into tgt and rd_sel, clear idx. Go to LOAD if cmd_store = 0, else CAPTURE.
- LOAD: s_ready = 1. Each s_valid && s_ready beat writes stage_vec[idx] <= s_data and increments idx. The beat with idx == N-1 moves to COMMIT and idx wraps to 0. No beats are accepted outside LOAD.
- COMMIT: exactly one cycle. reg_set = one-hot(tgt), reg_en = 1, done = 1. Next state IDLE. stage_vec is held stable during this cycle and after it, until the next LOAD beat.
- CAPTURE: one cycle, entered after rd_sel has settled for one cycle. stage_vec <= rd_vec, idx = 0. Next state STORE.
- STORE:
  - m_valid = 1 and m_data = stage_vec[idx].
  - m_data must stay stable while m_valid && !m_ready.
  - On m_valid && m_ready, idx increments.
  - On the beat with idx == N-1: done = 1 in the same cycle as that final beat, idx wraps to 0, next state IDLE.
  - The register bank is never written during a store.

Latency:
- Load: one command cycle + N beat cycles (minimum) + 1 commit cycle.
- Store: first m_valid appears 2 cycles after command acceptance.

Boundaries:
- Back-to-back commands: a new command can be accepted the cycle after done.
- cmd_valid while busy: stalls, because cmd_ready = 0.
- s_valid gaps in LOAD: idx holds.
- m_ready low in STORE: data and idx hold.
- cmd_reg >= NREGS: reg_set stays all-zero in COMMIT. done still pulses; the command is dropped safely.
- N = 1: LOAD commits after a single beat.

Optional Feature:
Macro: VEC_XFER_ABORT_EN.
- Defined: adds input port abort (1 bit). In LOAD, CAPTURE or STORE, abort = 1 returns to IDLE on the next edge with idx = 0, no reg_set pulse, m_valid deasserted, and done not pulsed. abort has priority over a simultaneous beat. abort in IDLE or COMMIT is ignored, so a commit always completes.
- Undefined: no abort port; commands always run to completion or reset.

Test Plan:
- Reset then load cmd_reg = 2 with s_data = 0x00..0x3F, no gaps -> s_ready for exactly 64 beats; one cycle with reg_set = 4'b0100 and reg_en = 1; stage_vec[k] = k; done pulses once.
- Store cmd_reg = 1 with rd_vec[k] = 0xFF - k and m_ready toggling 1/0 -> m_data sequence 0xFF..0xC0 with no duplicates or skips; data held during stalls; done coincides with the 64th beat.
- Load with s_valid randomly low 50% of cycles -> same commit result as the gap-free case; commit occurs only after the 64th accepted beat.
- rst asserted after 10 load beats, then a full load to reg 0 -> no reg_set pulse before the reset; stage_vec reads 0 after reset; the second load commits reg_set = 4'b0001 with the new data.
- cmd_valid held high during a load and s_valid asserted in IDLE -> cmd_ready = 0 until done; s_ready = 0 in IDLE; the second command is accepted the cycle after done.
- With VEC_XFER_ABORT_EN: abort after 5 load beats -> back to IDLE; reg_set never asserted; done never asserted.
